// File: rtl/classificador_palavras_param.sv
// Note-sequence word classifier: walks the adjective / comparative / adverb grammar one
// note per ok rising edge, with programmable prefix, inactivity timeout, rearm and counters.
module classificador_palavras_param #(
  parameter int                NOTE_W     = 4,
  parameter int                PREFIX_LEN = 2,
  parameter logic [NOTE_W-1:0] LA_BAIXO   = NOTE_W'(4'b1110),
  parameter logic [NOTE_W-1:0] SI_BAIXO   = NOTE_W'(4'b1111),
  parameter logic [NOTE_W-1:0] DO_ALTO    = NOTE_W'(4'b0001),
  parameter logic [NOTE_W-1:0] RE_ALTO    = NOTE_W'(4'b0010),
  parameter int                TIMEOUT    = 0,
  parameter int                REARM      = 0,
  parameter int                COUNT_W    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ok,
  input  logic [NOTE_W-1:0]  nota,
  output logic               fim,
  output logic [1:0]         tipo,
  output logic               fim_pulse,
  output logic [COUNT_W-1:0] cnt_erro,
  output logic [COUNT_W-1:0] cnt_adj,
  output logic [COUNT_W-1:0] cnt_cmp,
  output logic [COUNT_W-1:0] cnt_adv
);

  typedef enum logic [3:0] {
    IDLE, PRE, MARK, LA, SI, LA_DO, SI_RE, LA_SI, F_ERR, F_ADJ, F_CMP, F_ADV
  } state_t;

  localparam int PCNT_W = (PREFIX_LEN < 2) ? 1 : $clog2(PREFIX_LEN);
  localparam int TCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [PCNT_W-1:0] PLAST  = PCNT_W'(PREFIX_LEN - 1);
  localparam logic [TCNT_W-1:0] TLAST  = TCNT_W'(TIMEOUT - 1);
  localparam logic [NOTE_W-1:0] INV_HI = {1'b1, {(NOTE_W-1){1'b0}}};
  localparam logic [COUNT_W-1:0] CMAX  = {COUNT_W{1'b1}};

  state_t              state_r, next_state_s;
  logic                ok_q_r;
  logic [PCNT_W-1:0]   pcnt_r, next_pcnt_s;
  logic [TCNT_W-1:0]   tcnt_r, next_tcnt_s;
  logic                accept_s, term_s, active_s, enter_s;

  function automatic logic is_final(input state_t s);
    case (s)
      F_ERR, F_ADJ, F_CMP, F_ADV: is_final = 1'b1;
      default:                    is_final = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] tipo_of(input state_t s);
    case (s)
      LA, SI, F_ADJ:        tipo_of = 2'b01;
      LA_DO, SI_RE, F_CMP:  tipo_of = 2'b10;
      LA_SI, F_ADV:         tipo_of = 2'b11;
      default:              tipo_of = 2'b00;
    endcase
  endfunction

  assign accept_s = ok & ~ok_q_r;
  assign term_s   = (nota == {NOTE_W{1'b0}}) || (nota == INV_HI);
  assign active_s = (state_r != IDLE) && !is_final(state_r);
  // A rearmed word ending straight into a final state still counts as a new entry
  assign enter_s  = is_final(next_state_s) &&
                    (!is_final(state_r) || (accept_s && (REARM != 0)));

  // Next-state, prefix counter and inactivity timer
  always_comb begin
    next_state_s = state_r;
    next_pcnt_s  = pcnt_r;
    next_tcnt_s  = {TCNT_W{1'b0}};
    if (accept_s) begin
      case (state_r)
        IDLE, F_ERR, F_ADJ, F_CMP, F_ADV: begin
          if (state_r != IDLE && REARM == 0) next_state_s = state_r;
          else if (term_s)                   next_state_s = F_ERR;
          else if (PREFIX_LEN == 1)          next_state_s = MARK;
          else begin
            next_state_s = PRE;
            next_pcnt_s  = PCNT_W'(1'b1);
          end
        end
        PRE: begin
          if (term_s)                next_state_s = F_ERR;
          else if (pcnt_r == PLAST)  next_state_s = MARK;
          else begin
            next_state_s = PRE;
            next_pcnt_s  = pcnt_r + PCNT_W'(1'b1);
          end
        end
        MARK: begin
          if (term_s)                  next_state_s = F_ERR;
          else if (nota == LA_BAIXO)   next_state_s = LA;
          else if (nota == SI_BAIXO)   next_state_s = SI;
          else                         next_state_s = F_ERR;
        end
        LA: begin
          if (term_s)                  next_state_s = F_ADJ;
          else if (nota == DO_ALTO)    next_state_s = LA_DO;
          else if (nota == SI_BAIXO)   next_state_s = LA_SI;
          else                         next_state_s = F_ERR;
        end
        SI: begin
          if (term_s)                  next_state_s = F_ADJ;
          else if (nota == RE_ALTO)    next_state_s = SI_RE;
          else                         next_state_s = F_ERR;
        end
        LA_DO, SI_RE: next_state_s = term_s ? F_CMP : F_ERR;
        LA_SI:        next_state_s = term_s ? F_ADV : F_ERR;
        default:      next_state_s = F_ERR;
      endcase
    end else if (active_s) begin
      if (TIMEOUT > 0 && tcnt_r == TLAST) next_state_s = F_ERR;
      else                                 next_tcnt_s  = tcnt_r + TCNT_W'(1'b1);
    end else begin
      next_state_s = state_r;
    end
  end

  // State, registered Moore outputs and saturating result counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      ok_q_r    <= 1'b0;
      pcnt_r    <= {PCNT_W{1'b0}};
      tcnt_r    <= {TCNT_W{1'b0}};
      fim       <= 1'b0;
      tipo      <= 2'b00;
      fim_pulse <= 1'b0;
      cnt_erro  <= {COUNT_W{1'b0}};
      cnt_adj   <= {COUNT_W{1'b0}};
      cnt_cmp   <= {COUNT_W{1'b0}};
      cnt_adv   <= {COUNT_W{1'b0}};
    end else begin
      state_r   <= next_state_s;
      ok_q_r    <= ok;
      pcnt_r    <= next_pcnt_s;
      tcnt_r    <= next_tcnt_s;
      fim       <= is_final(next_state_s);
      tipo      <= tipo_of(next_state_s);
      fim_pulse <= enter_s;
      if (enter_s) begin
        case (tipo_of(next_state_s))
          2'b00:   if (cnt_erro != CMAX) cnt_erro <= cnt_erro + COUNT_W'(1'b1);
          2'b01:   if (cnt_adj  != CMAX) cnt_adj  <= cnt_adj  + COUNT_W'(1'b1);
          2'b10:   if (cnt_cmp  != CMAX) cnt_cmp  <= cnt_cmp  + COUNT_W'(1'b1);
          2'b11:   if (cnt_adv  != CMAX) cnt_adv  <= cnt_adv  + COUNT_W'(1'b1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_classificador_palavras_param.sv
// Bench: four classifier configurations share one note stream and are compared every
// cycle against a word-list reference model; directed scenarios precede a random phase.
module tb_classificador_palavras_param;

  localparam int P = 2;
  int p_to [4] = '{0, 5, 0, 0};
  int p_ra [4] = '{0, 0, 1, 1};
  int p_cw [4] = '{8, 8, 8, 2};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ok    = 1'b0;
  logic [3:0] nota  = 4'h0;

  logic       fim_w   [4];
  logic [1:0] tipo_w  [4];
  logic       pulse_w [4];
  logic [7:0] cnt_w   [4][4];

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : gd
    localparam int TOG = (g == 1) ? 5 : 0;
    localparam int RAG = (g >= 2) ? 1 : 0;
    localparam int CWG = (g == 3) ? 2 : 8;
    logic [CWG-1:0] ce, ca, cc, cv;
    classificador_palavras_param #(.TIMEOUT(TOG), .REARM(RAG), .COUNT_W(CWG)) dut (
      .clock(clock), .reset(reset), .ok(ok), .nota(nota),
      .fim(fim_w[g]), .tipo(tipo_w[g]), .fim_pulse(pulse_w[g]),
      .cnt_erro(ce), .cnt_adj(ca), .cnt_cmp(cc), .cnt_adv(cv)
    );
    assign cnt_w[g][0] = 8'(ce);
    assign cnt_w[g][1] = 8'(ca);
    assign cnt_w[g][2] = 8'(cc);
    assign cnt_w[g][3] = 8'(cv);
  end

  // reference model: the current word as a list of notes, classified as a whole
  logic [3:0] m_w [4][8];
  int         m_len [4];
  bit         m_done [4];
  bit         m_okq [4];
  bit         m_pulse [4];
  logic [1:0] m_ftipo [4];
  logic [1:0] m_cur [4];
  int         m_idle [4];
  int         m_cnt [4][4];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit inval(input logic [3:0] n);
    return (n == 4'h0) || (n == 4'h8);
  endfunction

  // {final, tipo} of the word collected so far
  function automatic logic [2:0] classify(input int g);
    int n;
    logic [3:0] mk, s;
    logic [1:0] t;
    n = m_len[g];
    for (int k = 0; k < n && k < P; k++)
      if (inval(m_w[g][k])) return 3'b100;
    if (n <= P) return 3'b000;
    mk = m_w[g][P];
    if (mk != 4'hE && mk != 4'hF) return 3'b100;
    if (n == P + 1) return 3'b001;
    s = m_w[g][P+1];
    if (inval(s)) return 3'b101;
    if (mk == 4'hE && s == 4'h1)      t = 2'b10;
    else if (mk == 4'hE && s == 4'hF) t = 2'b11;
    else if (mk == 4'hF && s == 4'h2) t = 2'b10;
    else return 3'b100;
    if (n == P + 2) return {1'b0, t};
    if (inval(m_w[g][P+2])) return {1'b1, t};
    return 3'b100;
  endfunction

  task automatic model_init(input int g);
    m_len[g] = 0; m_done[g] = 0; m_okq[g] = 0; m_pulse[g] = 0;
    m_ftipo[g] = 2'b00; m_cur[g] = 2'b00; m_idle[g] = 0;
    for (int k = 0; k < 4; k++) m_cnt[g][k] = 0;
  endtask

  task automatic model_finish(input int g, input logic [1:0] t);
    m_done[g] = 1; m_ftipo[g] = t; m_pulse[g] = 1;
    if (m_cnt[g][t] < (1 << p_cw[g]) - 1) m_cnt[g][t]++;
  endtask

  task automatic model_step(input int g);
    bit acc;
    logic [2:0] r;
    acc = ok && !m_okq[g];
    m_okq[g] = ok;
    m_pulse[g] = 0;
    if (m_done[g] && acc && p_ra[g] != 0) begin
      m_len[g] = 0; m_done[g] = 0; m_cur[g] = 2'b00;
    end
    if (!m_done[g]) begin
      if (acc) begin
        m_w[g][m_len[g]] = nota;
        m_len[g]++;
        m_idle[g] = 0;
        r = classify(g);
        m_cur[g] = r[1:0];
        if (r[2]) model_finish(g, r[1:0]);
      end else if (m_len[g] > 0) begin
        m_idle[g]++;
        if (p_to[g] > 0 && m_idle[g] == p_to[g]) model_finish(g, 2'b00);
      end
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < 4; g++) begin
      check_eq($sformatf("d%0d_fim", g), 32'(fim_w[g]), 32'(m_done[g]));
      check_eq($sformatf("d%0d_tipo", g), 32'(tipo_w[g]),
               32'(m_done[g] ? m_ftipo[g] : m_cur[g]));
      check_eq($sformatf("d%0d_pulse", g), 32'(pulse_w[g]), 32'(m_pulse[g]));
      for (int k = 0; k < 4; k++)
        check_eq($sformatf("d%0d_cnt%0d", g, k), 32'(cnt_w[g][k]), 32'(m_cnt[g][k]));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    for (int g = 0; g < 4; g++) begin
      if (reset) model_init(g);
      else       model_step(g);
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ok    = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_note(input logic [3:0] n, input int hold, input int gap);
    nota = n;
    ok   = 1'b1;
    repeat (hold) tick();
    ok = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] d, input logic [3:0] e, input int len);
    logic [3:0] w [5];
    w = '{a, b, c, d, e};
    for (int k = 0; k < len; k++) send_note(w[k], 1, 1);
  endtask

  function automatic logic [3:0] rand_note();
    case ($urandom_range(0, 7))
      0:       return 4'h0;
      1:       return 4'h8;
      2:       return 4'h1;
      3:       return 4'h2;
      4:       return 4'hE;
      5:       return 4'hF;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    int cyc;
    for (int g = 0; g < 4; g++) model_init(g);
    do_reset();
    check_eq("rst_fim", 32'(fim_w[0]), 32'd0);
    check_eq("rst_tipo", 32'(tipo_w[0]), 32'd0);

    send_word(4'h3, 4'h5, 4'hE, 4'h0, 4'h0, 4);
    check_eq("adj_fim", 32'(fim_w[0]), 32'd1);
    check_eq("adj_tipo", 32'(tipo_w[0]), 32'd1);
    check_eq("adj_cnt", 32'(cnt_w[0][1]), 32'd1);

    send_word(4'h3, 4'h5, 4'hF, 4'h0, 4'h0, 4);
    check_eq("rearm_cnt", 32'(cnt_w[2][1]), 32'd2);
    check_eq("hold_cnt", 32'(cnt_w[0][1]), 32'd1);
    check_eq("hold_tipo", 32'(tipo_w[0]), 32'd1);

    do_reset();
    send_word(4'h3, 4'h5, 4'hE, 4'h1, 4'h0, 5);
    check_eq("cmp_la_tipo", 32'(tipo_w[0]), 32'd2);
    do_reset();
    send_word(4'h3, 4'h5, 4'hE, 4'hF, 4'h0, 5);
    check_eq("adv_tipo", 32'(tipo_w[0]), 32'd3);
    do_reset();
    send_word(4'h3, 4'h5, 4'hF, 4'h2, 4'h0, 5);
    check_eq("cmp_si_tipo", 32'(tipo_w[0]), 32'd2);
    do_reset();
    send_word(4'h3, 4'h8, 4'h0, 4'h0, 4'h0, 2);
    check_eq("err_fim", 32'(fim_w[0]), 32'd1);
    check_eq("err_tipo", 32'(tipo_w[0]), 32'd0);

    do_reset();
    send_note(4'h3, 10, 1);
    send_word(4'h5, 4'hE, 4'h0, 4'h0, 4'h0, 3);
    check_eq("okhold_tipo", 32'(tipo_w[0]), 32'd1);

    do_reset();
    send_note(4'h3, 1, 0);
    cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (fim_w[1]) begin cyc = c; break; end
    end
    check_eq("timeout_cycles", 32'(cyc), 32'd5);
    check_eq("timeout_tipo", 32'(tipo_w[1]), 32'd0);
    check_eq("timeout_cnt", 32'(cnt_w[1][0]), 32'd1);

    do_reset();
    repeat (5) send_word(4'h3, 4'h5, 4'hE, 4'h0, 4'h0, 4);
    check_eq("sat_cnt", 32'(cnt_w[3][1]), 32'd3);
    check_eq("nosat_cnt", 32'(cnt_w[2][1]), 32'd5);

    send_word(4'h3, 4'h5, 4'h0, 4'h0, 4'h0, 2);
    #3 reset = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) model_init(g);
    check_all();
    check_eq("async_cnt", 32'(cnt_w[2][1]), 32'd0);
    tick();
    reset = 1'b0;

    for (int w = 0; w < 60; w++) begin
      if ($urandom_range(0, 2) == 0) do_reset();
      for (int k = 0, len = $urandom_range(1, 5); k < len; k++)
        send_note(rand_note(),
                  ($urandom_range(0, 5) == 0) ? $urandom_range(2, 4) : 1,
                  ($urandom_range(0, 7) == 0) ? $urandom_range(4, 8) : $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
